// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand sequencer front end:
// sequence states, ALU field widths, flag bit positions and config-byte layout.
package alu_pkg;

  typedef enum logic [2:0] {
    LOAD_A   = 3'd0,
    LOAD_B   = 3'd1,
    LOAD_CFG = 3'd2,
    EXEC     = 3'd3,
    DONE     = 3'd4
  } seq_state_e;

  localparam int unsigned ALU_CTRL_W  = 3;
  localparam int unsigned ALU_SHIFT_W = 2;
  localparam int unsigned ALU_FLAGS_W = 4;

  localparam int unsigned FLAG_ZERO  = 3;
  localparam int unsigned FLAG_NEG   = 2;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_OVF   = 0;

  localparam int unsigned CFG_CTRL_LSB  = 0;
  localparam int unsigned CFG_SHIFT_LSB = 3;

  // Status display byte: {Z, N, C, V, 0, state}.
  function automatic logic [7:0] status_pack(input logic [ALU_FLAGS_W-1:0] flags,
                                             input logic [2:0]             state);
    return {flags[FLAG_ZERO], flags[FLAG_NEG], flags[FLAG_CARRY], flags[FLAG_OVF],
            1'b0, state};
  endfunction

endpackage

// File: rtl/alu_operand_sequencer_btn_edge_sync.sv
// Button synchronizer followed by a one-cycle rising-edge pulse generator.
module btn_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Loads ALU operand A, operand B and a config byte over three button presses,
// drives the ALU from registers and captures its result one cycle later.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   btn,
  input  logic                   clr,
  input  logic                   disp_sel,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [ALU_CTRL_W-1:0]  alu_ctrl,
  output logic [ALU_SHIFT_W-1:0] alu_shift,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic [ALU_FLAGS_W-1:0] alu_flags,
  output logic [WIDTH-1:0]       disp_out,
  output logic                   busy,
  output logic                   done
);

  seq_state_e             state_q, state_d;
  logic                   load_evt;
  logic                   ld_a, ld_b, ld_cfg, capture;
  logic [WIDTH-1:0]       result_q;
  logic [ALU_FLAGS_W-1:0] flags_q;
  logic [WIDTH-1:0]       status_word;

  btn_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn_edge_sync (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .evt(load_evt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD_A;
    else     state_q <= state_d;
  end

  // clr wins over everything, including the EXEC capture.
  always_comb begin
    state_d = state_q;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_cfg  = 1'b0;
    capture = 1'b0;
    if (clr) begin
      state_d = LOAD_A;
    end else begin
      unique case (state_q)
        LOAD_A: if (load_evt) begin
          ld_a    = 1'b1;
          state_d = LOAD_B;
        end
        LOAD_B: if (load_evt) begin
          ld_b    = 1'b1;
          state_d = LOAD_CFG;
        end
        LOAD_CFG: if (load_evt) begin
          ld_cfg  = 1'b1;
          state_d = EXEC;
        end
        EXEC: begin
          capture = 1'b1;
          state_d = DONE;
        end
        DONE: if (load_evt) begin
          ld_a    = 1'b1;
          state_d = LOAD_B;
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      alu_shift <= '0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      if (ld_a) alu_a <= data_in;
      if (ld_b) alu_b <= data_in;
      if (ld_cfg) begin
        alu_ctrl  <= data_in[CFG_CTRL_LSB +: ALU_CTRL_W];
        alu_shift <= data_in[CFG_SHIFT_LSB +: ALU_SHIFT_W];
      end
      if (capture) begin
        result_q <= alu_result;
        flags_q  <= alu_flags;
      end
    end
  end

  assign busy = (state_q == EXEC);
  assign done = (state_q == DONE);

  assign status_word = WIDTH'(status_pack(flags_q, state_q));
  assign disp_out    = disp_sel ? status_word : result_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: directed table, timed corner sequences and
// randomized press/abort traffic against an operation-level model.
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       btn, clr, disp_sel;
  logic [7:0] alu_a, alu_b, alu_result, disp_out;
  logic [2:0] alu_ctrl;
  logic [1:0] alu_shift;
  logic [3:0] alu_flags;
  logic       busy, done;

  logic       ovr_en;
  logic [3:0] ovr_flags;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(
    .WIDTH(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .btn(btn), .clr(clr),
    .disp_sel(disp_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_shift(alu_shift), .alu_result(alu_result), .alu_flags(alu_flags),
    .disp_out(disp_out), .busy(busy), .done(done)
  );

  // Stand-in ALU: returns {Z, N, C, V, result}.
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] c, input logic [1:0] s);
    logic [8:0] w;
    logic [7:0] r;
    logic       cy, ov;
    w = '0; r = '0; cy = 1'b0; ov = 1'b0;
    case (c)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; cy = w[8];
                  ov = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd3: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; cy = w[8];
                  ov = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd4: r = a ^ b;
      3'd5: r = a << s;
      3'd6: r = a >> s;
      default: r = ~a;
    endcase
    return {(r == 8'd0), r[7], cy, ov, r};
  endfunction

  always_comb begin
    logic [11:0] f;
    f          = alu_ref(alu_a, alu_b, alu_ctrl, alu_shift);
    alu_result = f[7:0];
    alu_flags  = ovr_en ? ovr_flags : f[11:8];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic rd_disp(input logic sel, output logic [7:0] v);
    disp_sel = sel;
    #1;
    v = disp_out;
  endtask

  task automatic press(input logic [7:0] d, input int hold);
    @(negedge clk);
    data_in = d;
    btn     = 1'b1;
    repeat (hold) @(negedge clk);
    btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [2:0] st;
    logic [7:0] a, b;
    logic [2:0] c;
    logic [1:0] s;
    logic [7:0] res;
    logic [3:0] fl;
  } vec_t;

  vec_t tbl[6];

  // Operation-level model for the random phase.
  int         m_phase;
  logic [7:0] m_a, m_b, m_res;
  logic [2:0] m_c;
  logic [1:0] m_s;
  logic [3:0] m_fl;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic [11:0] f;

    rst = 1'b1; data_in = '0; btn = 1'b0; clr = 1'b0; disp_sel = 1'b0;
    ovr_en = 1'b0; ovr_flags = '0;

    tbl[0] = '{8'h05, 3'd1, 8'h05, 8'h00, 3'd0, 2'd0, 8'h00, 4'b0000};
    tbl[1] = '{8'h0A, 3'd2, 8'h05, 8'h0A, 3'd0, 2'd0, 8'h00, 4'b0000};
    tbl[2] = '{8'h02, 3'd4, 8'h05, 8'h0A, 3'd2, 2'd0, 8'h0F, 4'b0000};
    tbl[3] = '{8'hFF, 3'd1, 8'hFF, 8'h0A, 3'd2, 2'd0, 8'h0F, 4'b0000};
    tbl[4] = '{8'h80, 3'd2, 8'hFF, 8'h80, 3'd2, 2'd0, 8'h0F, 4'b0000};
    tbl[5] = '{8'h1A, 3'd4, 8'hFF, 8'h80, 3'd2, 2'd3, 8'h7F, 4'b0011};

    repeat (2) @(negedge clk);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_busy_done", {busy, done}, 2'b00);
    rd_disp(1'b1, v); chk("rst_disp_status", v, 8'h00);
    rst = 1'b0;

    // Directed table
    foreach (tbl[i]) begin
      press(tbl[i].data, 4);
      chk($sformatf("tbl%0d_a", i), alu_a, tbl[i].a);
      chk($sformatf("tbl%0d_b", i), alu_b, tbl[i].b);
      chk($sformatf("tbl%0d_cfg", i), {alu_ctrl, alu_shift}, {tbl[i].c, tbl[i].s});
      chk($sformatf("tbl%0d_busy_done", i), {busy, done}, {1'b0, tbl[i].st == 3'd4});
      rd_disp(1'b0, v); chk($sformatf("tbl%0d_result", i), v, tbl[i].res);
      rd_disp(1'b1, v); chk($sformatf("tbl%0d_status", i), v, {tbl[i].fl, 1'b0, tbl[i].st});
    end

    // Asynchronous reset mid-cycle
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_ops", {alu_a, alu_b, alu_ctrl, alu_shift}, 21'd0);
    chk("arst_busy_done", {busy, done}, 2'b00);
    rd_disp(1'b0, v); chk("arst_result", v, 8'h00);
    rd_disp(1'b1, v); chk("arst_status", v, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Held button: one event, load at edge k+2
    @(negedge clk);
    data_in = 8'h3C; btn = 1'b1;
    @(negedge clk);
    rd_disp(1'b1, v); chk("held_k_state", v[2:0], 3'd0);
    @(negedge clk);
    rd_disp(1'b1, v); chk("held_k1_state", v[2:0], 3'd0);
    chk("held_k1_a", alu_a, 8'h00);
    @(negedge clk);
    rd_disp(1'b1, v); chk("held_k2_state", v[2:0], 3'd1);
    chk("held_k2_a", alu_a, 8'h3C);
    repeat (47) @(negedge clk);
    rd_disp(1'b1, v); chk("held_50_state", v[2:0], 3'd1);
    chk("held_50_b", alu_b, 8'h00);
    btn = 1'b0;
    repeat (4) @(negedge clk);

    // Abort coincident with a load event
    data_in = 8'h77; btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    rd_disp(1'b1, v); chk("abort_state", v[2:0], 3'd0);
    chk("abort_ops", {alu_a, alu_b}, {8'h3C, 8'h00});
    repeat (3) @(negedge clk);
    rd_disp(1'b1, v); chk("abort_dropped", v[2:0], 3'd0);
    btn = 1'b0;
    repeat (4) @(negedge clk);

    // Timed config load with forced flags
    press(8'h40, 3);
    press(8'h03, 3);
    ovr_en = 1'b1; ovr_flags = 4'b1010;
    data_in = 8'h0B; btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rd_disp(1'b1, v); chk("cfg_k1_state", v[2:0], 3'd2);
    @(negedge clk);
    chk("exec_busy_done", {busy, done}, 2'b10);
    rd_disp(1'b0, v); chk("exec_result_old", v, 8'h00);
    chk("exec_cfg", {alu_ctrl, alu_shift}, {3'd3, 2'd1});
    @(negedge clk);
    chk("done_busy_done", {busy, done}, 2'b01);
    rd_disp(1'b1, v); chk("done_flag_disp", v, 8'hA4);
    rd_disp(1'b0, v); chk("done_result", v, 8'h3D);
    btn = 1'b0; ovr_en = 1'b0;
    repeat (4) @(negedge clk);

    // Rerun from DONE keeps captured result and flags
    press(8'hFF, 3);
    chk("rerun_a", alu_a, 8'hFF);
    rd_disp(1'b1, v); chk("rerun_status", v, 8'hA1);
    rd_disp(1'b0, v); chk("rerun_result", v, 8'h3D);

    // Randomized traffic
    do_reset();
    m_phase = 0; m_a = '0; m_b = '0; m_c = '0; m_s = '0; m_res = '0; m_fl = '0;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_phase = 0;
      end else begin
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        press(d, int'($urandom_range(3, 8)));
        case (m_phase)
          1: begin m_b = d; m_phase = 2; end
          2: begin
            m_c = d[2:0]; m_s = d[4:3];
            f = alu_ref(m_a, m_b, m_c, m_s);
            m_res = f[7:0]; m_fl = f[11:8]; m_phase = 4;
          end
          default: begin m_a = d; m_phase = 1; end
        endcase
      end
      chk("rnd_ops", {alu_a, alu_b, alu_ctrl, alu_shift}, {m_a, m_b, m_c, m_s});
      rd_disp(1'b0, v); chk("rnd_result", v, m_res);
      rd_disp(1'b1, v); chk("rnd_status", v, {m_fl, 1'b0, 3'(m_phase)});
      chk("rnd_busy_done", {busy, done}, {1'b0, m_phase == 4});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
